// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common_pkg
// Description : Shared data-bus types used by the core and its memory
//               slaves: the access-size encoding and the request/response
//               structs for the data bus.
// Revision    : 1.0 - initial release
// ============================================================================
package common_pkg;

    // Access size; the memory returns full words, so this is informational.
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;   // byte write enables, all zero means read
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage : common_pkg
`default_nettype wire

// File: rtl/dbus_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_sram_pkg
// Description : FSM state encoding, LFSR seed and LFSR step function for the
//               data-bus SRAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_sram_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11 (bit 15 is tap 16).
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], fb};
    endfunction

endpackage : dbus_sram_pkg
`default_nettype wire

// File: rtl/sram_bytewrite.sv
`default_nettype none
// ============================================================================
// Module      : sram_bytewrite
// Description : DEPTH x 64-bit storage with per-byte write enables and an
//               asynchronous read port. Contents are not reset.
// Ports       : clk   - clock
//               we    - write enable (qualified per byte by be)
//               be    - byte enables, bit i covers wdata[8i+7:8i]
//               addr  - word index for both read and write
//               wdata - write data
//               rdata - combinational read data at addr
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bytewrite #(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [7:0]               be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [63:0]              wdata,
    output logic [63:0]              rdata
);

    // One independent byte-wide array per lane keeps each lane's write
    // enable separate and gives every array a single driver.
    for (genvar i = 0; i < 8; i++) begin : g_lane
        logic [7:0] r_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we && be[i]) begin
                r_mem[addr] <= wdata[8*i +: 8];
            end
        end

        assign rdata[8*i +: 8] = r_mem[addr];
    end

endmodule : sram_bytewrite
`default_nettype wire

// File: rtl/dbus_sram.sv
`default_nettype none
// ============================================================================
// Module      : dbus_sram
// Description : Data-bus SRAM slave. Accepts one request at a time in IDLE,
//               waits LATENCY cycles, then answers with a one-cycle data_ok.
//               Reads return the whole 64-bit word; writes are byte-strobed
//               and committed on the data_ok cycle. Out-of-range addresses
//               complete with zero data and an err pulse.
// Ports       : clk   - clock
//               reset - asynchronous active-high reset
//               dreq  - request from the core
//               dresp - response to the core
//               err   - out-of-range pulse, coincident with data_ok
// Options     : DBUS_SRAM_RANDOM_DELAY_EN - adds 0..3 pseudo-random extra
//               wait cycles per request from a 16-bit LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_sram
    import common_pkg::*;
    import dbus_sram_pkg::*;
#(
    parameter int          DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err
);

    localparam int          c_AW    = $clog2(DEPTH);
    localparam logic [63:0] c_LIMIT = BASE + 64'(DEPTH) * 64'd8;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_addr;
    msize_t      r_size;
    logic [7:0]  r_strobe;
    logic [63:0] r_wdata;

    logic            w_accept;
    logic [4:0]      w_extra;
    logic [4:0]      w_load;
    logic            w_in_range;
    logic [63:0]     w_off;
    logic [c_AW-1:0] w_idx;
    logic            w_data_ok;
    logic            w_is_write;
    logic            w_we;
    logic [63:0]     w_rdata;
    logic            w_unused;

    assign w_accept   = (r_state == c_ST_IDLE) && dreq.valid;
    assign w_load     = 5'(LATENCY - 1) + w_extra;
    assign w_in_range = (r_addr >= BASE) && (r_addr < c_LIMIT);
    assign w_off      = r_addr - BASE;
    assign w_idx      = w_off[c_AW+2:3];
    // A flush in RESP (valid low) suppresses data_ok and the write.
    assign w_data_ok  = (r_state == c_ST_RESP) && dreq.valid;
    assign w_is_write = |r_strobe;
    assign w_we       = w_data_ok && w_is_write && w_in_range;

    // Size and sub-word address bits do not affect a full-word memory.
    assign w_unused = &{1'b0, r_size, w_off[2:0], w_off[63:c_AW+3]};

`ifdef DBUS_SRAM_RANDOM_DELAY_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // Extra delay uses the value current at acceptance, before stepping.
    assign w_extra = {3'b000, r_lfsr[1:0]};
`else
    assign w_extra = 5'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= 5'd0;
            r_addr   <= 64'd0;
            r_size   <= MSIZE1;
            r_strobe <= 8'd0;
            r_wdata  <= 64'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (dreq.valid) begin
                        r_addr   <= dreq.addr;
                        r_size   <= dreq.size;
                        r_strobe <= dreq.strobe;
                        r_wdata  <= dreq.data;
                        r_cnt    <= w_load;
                        r_state  <= (w_load == 5'd0) ? c_ST_RESP : c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (!dreq.valid) begin
                        r_cnt   <= 5'd0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        // Leave when the count reaches zero, so data_ok
                        // lands exactly the loaded count + 1 cycles later.
                        r_cnt <= r_cnt - 5'd1;
                        if (r_cnt == 5'd1) begin
                            r_state <= c_ST_RESP;
                        end
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    sram_bytewrite #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .be    (r_strobe),
        .addr  (w_idx),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    always_comb begin
        dresp         = '0;
        // Gated by reset so nothing looks accepted while reset is held.
        dresp.addr_ok = w_accept && !reset;
        dresp.data_ok = w_data_ok;
        dresp.data    = (w_data_ok && !w_is_write && w_in_range) ? w_rdata : 64'd0;
    end

    assign err = w_data_ok && !w_in_range;

endmodule : dbus_sram
`default_nettype wire

// File: doc/dbus_sram.md
DBUS_SRAM -- requirements
Module: dbus_sram

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4096, meaning the number of 64-bit words of storage (power of two).
REQ-002 The block SHALL have parameter BASE, default 64'h8000_0000, meaning the byte address of word 0.
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning the minimum number of cycles from request acceptance to data_ok (legal range 1..15).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 The block SHALL have port dreq, input, dbus_req_t, meaning the data-bus request from the core (valid, addr, size, strobe, data).
REQ-007 The block SHALL have port dresp, output, dbus_resp_t, meaning the response to the core (addr_ok, data_ok, data).
REQ-008 The block SHALL have port err, output, 1, meaning a one-cycle pulse coincident with data_ok for an out-of-range address.

Function
REQ-009 The block SHALL implement FSM states IDLE, WAIT and RESP, all transitions on the rising edge of clk.
REQ-010 IDLE with dreq.valid=1 SHALL latch addr/size/strobe/data, load the delay counter with LATENCY-1 and move to WAIT (or to RESP if the loaded count is 0); dresp.addr_ok SHALL be 1 in that cycle.
REQ-011 WAIT SHALL decrement the counter each cycle and move to RESP when the counter equals 0.
REQ-012 RESP SHALL drive dresp.data_ok=1 for exactly one cycle and return to IDLE; the request is therefore answered LATENCY cycles after acceptance.
REQ-013 A read SHALL return the full 64-bit word at index (addr-BASE)>>3; the block SHALL NOT extract or sign-extend sub-word lanes.
REQ-014 A write (strobe!=0) SHALL update only the bytes whose strobe bit is 1, committed on the data_ok cycle; dresp.data SHALL be 0 for writes.
REQ-015 If dreq.valid falls in WAIT or RESP (pipeline flush), the block SHALL return to IDLE the next cycle with no write committed and no data_ok.
REQ-016 An address outside [BASE, BASE+8*DEPTH) SHALL complete normally with dresp.data=0, no write and err=1 during data_ok.
REQ-017 A new request presented in the cycle after data_ok SHALL be accepted in that cycle (back-to-back, no bubble beyond the IDLE cycle).
REQ-018 dresp.data SHALL be held stable only during data_ok and SHALL be 0 otherwise.

Reset
REQ-019 On reset assertion the FSM SHALL enter IDLE immediately; counter=0; dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, err=0.
REQ-020 Storage contents SHALL be unaffected by reset; a request in flight at reset SHALL be dropped with no write committed.

Configuration
REQ-021 With DBUS_SRAM_RANDOM_DELAY_EN defined, a 16-bit LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) SHALL add its low 2 bits (0..3) of extra WAIT cycles per request, advancing once per accepted request.
REQ-022 Without DBUS_SRAM_RANDOM_DELAY_EN, latency SHALL be exactly LATENCY cycles and no LFSR logic SHALL exist.

Structure
REQ-023 The dbus_req_t/dbus_resp_t structs and the msize_t encoding SHALL come from the shared common package; the FSM state enum and the LFSR seed constant SHALL go in a dbus_sram_pkg package.
REQ-024 Storage SHALL be a sub-module sram_bytewrite (DEPTH x 64, per-byte write enable, asynchronous read).

Verification
REQ-025 Write 0x1122334455667788 to 0x80000010 with strobe 8'hFF, then read the same address -> data_ok exactly 2 cycles after each acceptance; read data equals the written value.
REQ-026 Write 0xAABB with strobe 8'h03 to 0x80000010 over the prior value -> the read returns 0x112233445566AABB.
REQ-027 Read 0x70000000 -> data_ok with data 0 and err=1 in the same cycle; memory is unchanged.
REQ-028 Write 0xDEAD to 0x80000008, then drop valid one cycle after acceptance -> no data_ok; a later read of 0x80000008 returns the old value.
REQ-029 Assert reset while in WAIT -> all outputs are 0 immediately; the first request after reset is accepted on the first cycle it is presented.
REQ-030 With DBUS_SRAM_RANDOM_DELAY_EN defined, run 100 back-to-back reads -> every latency lies in 2..5, and the latency sequence matches the LFSR reference model from seed 16'hACE1.
